// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage.
//
// Contents:
//   XLEN        - architectural register / address width
//   NOP_INSTR   - canonical NOP encoding (addi x0, x0, 0)
//   fs_state_e  - fetch FSM state encoding (FS_REQ, FS_WAIT, FS_VALID)
//   pc_misaligned - true when a fetch address is not word aligned
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_WAIT  = 2'd1,
    FS_VALID = 2'd2
  } fs_state_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsbs);
    return pc_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit - instruction-fetch responder placed after the PC register.
//
// Runs one request/response transaction on the instruction-memory port for
// the current PC, registers the returned word and offers it to decode under
// a valid/ready handshake. The PC is held (fetch_stall) until decode accepts;
// a flush discards in-flight or held words. Only one transaction is ever
// outstanding, so there is no prefetch and no response reordering.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pc_in               - current fetch address from the PC register
//   flush               - redirect; pc_in carries the target from next cycle
//   imem_req/imem_addr  - memory request and address (address = pc_in)
//   imem_gnt            - memory accepted the request this cycle
//   imem_rvalid/rdata   - read response
//   instr_valid/instr_out/instr_pc - fetched instruction towards decode
//   de_ready            - decode accepts the instruction this cycle
//   fetch_stall         - high = hold the PC
//   misalign_err        - only with IFETCH_MISALIGN_CHECK_EN: the held word
//                         is a NOP standing in for a misaligned fetch
//
// Build option:
//   IFETCH_MISALIGN_CHECK_EN - when defined, a misaligned pc_in is not sent to
//   memory; a NOP tagged with misalign_err is presented instead.
module ifetch_unit #(
  parameter int ADDR_W = riscv_pkg::XLEN,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              de_ready,
  output logic              fetch_stall
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  import riscv_pkg::*;

  fs_state_e         state_p0, state_p1;
  logic              drop_p0, drop_p1;
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] instr_p0, instr_p1;
  logic [ADDR_W-1:0] pc_p0, pc_p1;
  logic              misalign_now;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic              merr_p0, merr_p1;
  assign misalign_now = pc_misaligned(pc_in[1:0]);
`else
  assign misalign_now = 1'b0;
`endif

  assign imem_req    = (state_p1 == FS_REQ) && !misalign_now;
  assign imem_addr   = pc_in;
  assign instr_valid = vld_p1;
  assign instr_out   = instr_p1;
  assign instr_pc    = pc_p1;
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign_err = merr_p1;
`endif

  // The PC advances only on the accepting edge, and always loads on a flush.
  assign fetch_stall = !(vld_p1 && de_ready && !flush) && !flush;

  always_comb begin
    state_p0 = state_p1;
    drop_p0  = drop_p1;
    vld_p0   = vld_p1;
    instr_p0 = instr_p1;
    pc_p0    = pc_p1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    merr_p0  = merr_p1;
`endif
    unique case (state_p1)
      FS_REQ: begin
`ifdef IFETCH_MISALIGN_CHECK_EN
        // A flush in this cycle means pc_in is stale; wait for the target.
        if (misalign_now) begin
          if (!flush) begin
            state_p0 = FS_VALID;
            vld_p0   = 1'b1;
            instr_p0 = NOP_INSTR;
            pc_p0    = pc_in;
            merr_p0  = 1'b1;
          end
        end else
`endif
        if (imem_gnt) begin
          pc_p0    = pc_in;
          state_p0 = FS_WAIT;
          // Granted with a stale address: let the response land, then drop it.
          drop_p0  = flush;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          if (drop_p1 || flush) begin
            drop_p0  = 1'b0;
            state_p0 = FS_REQ;
          end else begin
            instr_p0 = imem_rdata;
            vld_p0   = 1'b1;
            state_p0 = FS_VALID;
          end
        end else if (flush) begin
          drop_p0 = 1'b1;
        end
      end
      FS_VALID: begin
        // Flush takes priority over a simultaneous accept.
        if (flush || de_ready) begin
          vld_p0   = 1'b0;
          state_p0 = FS_REQ;
`ifdef IFETCH_MISALIGN_CHECK_EN
          merr_p0  = 1'b0;
`endif
        end
      end
      default: state_p0 = FS_REQ;
    endcase
    if (flush) begin
      instr_p0 = NOP_INSTR;
    end
  end

  // Output / FSM register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= FS_REQ;
      drop_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      merr_p1  <= 1'b0;
`endif
    end else begin
      state_p1 <= state_p0;
      drop_p1  <= drop_p0;
      vld_p1   <= vld_p0;
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      merr_p1  <= merr_p0;
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios followed by a randomized run
// against an environment model (PC register + single-outstanding memory with
// a fixed address->word content function).
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        de_ready;
  logic        fetch_stall;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .de_ready    (de_ready),
    .fetch_stall (fetch_stall)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Environment PC register: reset to 0, load target on flush, +4 when not stalled.
  logic [31:0] pc;
  logic [31:0] target;
  logic        fs_s, fl_s, rs_s;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    fs_s = fetch_stall;
    fl_s = flush;
    rs_s = reset;
    @(posedge clk);
    #1;
    if (rs_s)       pc = 32'h0;
    else if (fl_s)  pc = target;
    else if (!fs_s) pc = pc + 32'd4;
    pc_in = pc;
  endtask

  logic        pending;
  logic [31:0] paddr;
  int          dly;
  int          accepts;
  logic        hold_prev;
  logic [31:0] out_prev, pc_prev;

  initial begin
    reset = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; de_ready = 1'b0; pc = 32'h0; pc_in = 32'h0; target = 32'h0;
    tick();
    tick();
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_out", instr_out, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_req", imem_req, 1'b1);

    // Best-case latency: grant in cycle 0, rvalid cycle 1, valid cycle 2.
    reset = 1'b0; imem_gnt = 1'b1; #1;
    chk("c0_req", imem_req, 1'b1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_stall", fetch_stall, 1'b1);
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    chk("c1_req", imem_req, 1'b0);
    chk("c1_stall", fetch_stall, 1'b1);
    tick(); imem_rvalid = 1'b0; de_ready = 1'b1; #1;
    chk("c2_valid", instr_valid, 1'b1);
    chk("c2_pc", instr_pc, 32'h0);
    chk("c2_out", instr_out, 32'h0050_0093);
    chk("c2_stall", fetch_stall, 1'b0);
    tick(); de_ready = 1'b0; #1;
    chk("c3_valid", instr_valid, 1'b0);
    chk("c3_req", imem_req, 1'b1);
    chk("c3_addr", imem_addr, 32'h4);

    // Decode back-pressure for 5 cycles in VALID.
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick(); imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_out", instr_out, 32'h1111_2222);
      chk("bp_pc", instr_pc, 32'h4);
      chk("bp_stall", fetch_stall, 1'b1);
      chk("bp_req", imem_req, 1'b0);
      tick();
    end
    de_ready = 1'b1; #1;
    chk("bp_acc_stall", fetch_stall, 1'b0);
    tick(); de_ready = 1'b0;

    // Grant delayed 3 cycles at pc=8.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gd_req", imem_req, 1'b1);
      chk("gd_addr", imem_addr, 32'h8);
      chk("gd_stall", fetch_stall, 1'b1);
      tick();
    end
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0;

    // Flush in WAIT, redirect to 0x100; late data must be dropped.
    flush = 1'b1; target = 32'h100; #1;
    chk("fw_stall", fetch_stall, 1'b0);
    tick(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("fw_wait_req", imem_req, 1'b0);
    tick(); imem_rvalid = 1'b0; #1;
    chk("fw_valid", instr_valid, 1'b0);
    tests++;
    assert (instr_out !== 32'hDEAD_BEEF) else begin
      fails++;
      $error("FAIL fw_leak: observed %h expected anything but deadbeef", instr_out);
    end
    chk("fw_req", imem_req, 1'b1);
    chk("fw_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_0113;
    tick(); imem_rvalid = 1'b0; #1;
    chk("fw_dvalid", instr_valid, 1'b1);
    chk("fw_dpc", instr_pc, 32'h100);
    chk("fw_dout", instr_out, 32'h0020_0113);

    // Flush together with de_ready in VALID: flush wins.
    flush = 1'b1; de_ready = 1'b1; target = 32'h200; #1;
    chk("fv_stall", fetch_stall, 1'b0);
    tick(); flush = 1'b0; de_ready = 1'b0; #1;
    chk("fv_valid", instr_valid, 1'b0);
    chk("fv_out", instr_out, NOP);
    chk("fv_req", imem_req, 1'b1);
    chk("fv_addr", imem_addr, 32'h200);

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned target: no request, NOP tagged with misalign_err.
    flush = 1'b1; target = 32'h102;
    tick(); flush = 1'b0; #1;
    chk("ma_req", imem_req, 1'b0);
    tick(); #1;
    chk("ma_valid", instr_valid, 1'b1);
    chk("ma_err", misalign_err, 1'b1);
    chk("ma_pc", instr_pc, 32'h102);
    chk("ma_out", instr_out, NOP);
    chk("ma_stall", fetch_stall, 1'b1);
    flush = 1'b1; target = 32'h300;
    tick(); flush = 1'b0; #1;
    chk("ma_clr_err", misalign_err, 1'b0);
    chk("ma_clr_valid", instr_valid, 1'b0);
`endif

    // Reset mid-transaction; a stale response afterwards is ignored.
    reset = 1'b1;
    tick(); reset = 1'b0; imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; #1;
    chk("ra_req", imem_req, 1'b1);
    tick(); imem_rvalid = 1'b0; #1;
    chk("ra_valid", instr_valid, 1'b0);
    chk("ra_addr", imem_addr, 32'h0);

    // Randomized run against the environment model.
    pending = 1'b0; paddr = 32'h0; dly = 0; accepts = 0; hold_prev = 1'b0;
    out_prev = 32'h0; pc_prev = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pending) begin
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem(paddr);
          pending     = 1'b0;
        end else begin
          dly--;
        end
      end
      de_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      if (flush) target = $urandom & 32'h0000_FFFC;
      imem_gnt = 1'b0;
      #1;
      if (imem_req && !pending && ($urandom_range(0, 1) == 1)) begin
        imem_gnt = 1'b1;
        pending  = 1'b1;
        paddr    = imem_addr;
        dly      = $urandom_range(0, 3);
      end
      #1;
      if (imem_req) chk("rnd_addr", imem_addr, pc_in);
      chk("rnd_stall", fetch_stall, !(instr_valid && de_ready && !flush) && !flush);
      if (hold_prev) begin
        chk("rnd_hold_valid", instr_valid, 1'b1);
        chk("rnd_hold_out", instr_out, out_prev);
        chk("rnd_hold_pc", instr_pc, pc_prev);
      end
      if (instr_valid && de_ready && !flush) begin
        accepts++;
        chk("rnd_acc_pc", instr_pc, pc_in);
        chk("rnd_acc_out", instr_out, mem(instr_pc));
      end
      hold_prev = instr_valid && !de_ready && !flush;
      out_prev  = instr_out;
      pc_prev   = instr_pc;
    end
    chk("rnd_progress", (accepts > 100), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
